psg_write_fifo: RTL and testbench
=================================

PSG_WRITE_FIFO -- requirements
Module: psg_write_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8: FIFO entries; power of two, 2..64.
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 32: clk cycles from one write strobe to the next; 2..255.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  8  host register-write byte, SN76489 latch/data format.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept; equals !full.
REQ-008 SHALL have port psg_data  output  8  byte driven to the PSG data bus.
REQ-009 SHALL have port psg_we_n  output  1  active-low write strobe to the PSG /WE pin.
REQ-010 SHALL have port busy  output  1  high when the FIFO is non-empty or the FSM is not IDLE.

Function
REQ-011 SHALL push in_data on any rising edge where in_valid && in_ready; no push otherwise.
REQ-012 SHALL be a non-fall-through FIFO: a byte pushed on edge k is poppable no earlier than edge k+1.
REQ-013 SHALL implement FSM states IDLE, STROBE, HOLD; psg_data and psg_we_n registered.
REQ-014 IDLE: if FIFO non-empty, pop the head, load psg_data, drive psg_we_n=0, go to STROBE; else stay.
REQ-015 STROBE: psg_we_n=0 for exactly one cycle; load hold counter with HOLDOFF_CYCLES-2; go to HOLD.
REQ-016 HOLD: psg_we_n=1; decrement counter; at 0, pop and go to STROBE if non-empty, else go to IDLE.
REQ-017 Byte accepted on edge k into an empty FIFO with FSM IDLE SHALL appear as psg_we_n=0 exactly between edges k+1 and k+2.
REQ-018 With a backlog, strobe starts SHALL be exactly HOLDOFF_CYCLES cycles apart; FIFO order preserved.
REQ-019 psg_data SHALL hold the last written byte until the next pop; psg_we_n never low two consecutive cycles.
REQ-020 Push and pop on the same edge SHALL both take effect; occupancy unchanged.
REQ-021 When full, in_ready=0; a push and a pop on the same edge is not possible; in_ready rises the cycle after a pop.
REQ-022 Read/write pointers SHALL be $clog2(DEPTH) bits, wrapping modulo DEPTH; occupancy counter $clog2(DEPTH)+1 bits.

Reset
REQ-023 On reset: FIFO empty, pointers 0, FSM IDLE, hold counter 0, psg_data=8'h00, psg_we_n=1, busy=0, in_ready=1.
REQ-024 Reset mid-STROBE or mid-HOLD SHALL deassert psg_we_n on the next edge and discard all queued bytes.

Configuration
REQ-025 Macro PSG_WRITE_FIFO_LEVEL_EN defined SHALL add output port level  output  $clog2(DEPTH)+1  current occupancy, reset 0.
REQ-026 Macro PSG_WRITE_FIFO_LEVEL_EN undefined SHALL omit the level port; all other behaviour identical.

Structure
REQ-027 Shared package psg_pkg SHALL hold the FSM state enum (IDLE/STROBE/HOLD), PSG_BYTE_W=8, and default DEPTH/HOLDOFF_CYCLES.
REQ-028 SHALL instantiate one sub-module psg_byte_fifo (storage, pointers, occupancy, full/empty); the FSM lives in psg_write_fifo.

Verification
REQ-029 Push single byte 8'h8F on edge 10, FSM idle -> psg_we_n=0, psg_data=8'h8F during cycle 11..12 only; busy falls after HOLD ends.
REQ-030 Push 8'h80,8'h3F,8'h9A back-to-back, HOLDOFF_CYCLES=32 -> three strobes at s, s+32, s+64, in order.
REQ-031 Push 9 bytes with DEPTH=8, no pops possible yet -> in_ready=0 after 8 stored; 9th accepted only after first pop; all 9 emitted in order.
REQ-032 Simultaneous push and pop with occupancy 3 -> occupancy stays 3; level=3 when PSG_WRITE_FIFO_LEVEL_EN defined.
REQ-033 Assert reset during HOLD with 4 bytes queued -> psg_we_n=1, busy=0, in_ready=1 next edge; no further strobes after reset release.
REQ-034 Pointer wrap: push/pop 20 bytes 8'h00..8'h13 through DEPTH=8 -> psg_data sequence 8'h00..8'h13 exactly, no duplicates.

Source files
------------

// File: rtl/psg_pkg.sv
// Shared types and defaults for the PSG write FIFO: FSM state encoding, bus width, default sizing.
package psg_pkg;

  localparam int unsigned PSG_BYTE_W          = 8;
  localparam int unsigned PSG_DEFAULT_DEPTH   = 8;
  localparam int unsigned PSG_DEFAULT_HOLDOFF = 32;
  localparam int unsigned PSG_HOLD_W          = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    HOLD   = 2'd2
  } psg_state_e;

endpackage

// File: rtl/psg_byte_fifo.sv
// Byte FIFO with registered storage: a byte pushed on one edge is visible at the head from the next cycle.
module psg_byte_fifo
  import psg_pkg::*;
#(
  parameter int unsigned DEPTH = PSG_DEFAULT_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [PSG_BYTE_W-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [PSG_BYTE_W-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o
);

  logic [PSG_BYTE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push;
  logic                  do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/psg_write_fifo.sv
// Queues host register writes and replays them to an SN76489 with a fixed strobe-to-strobe spacing.
// Optional: define PSG_WRITE_FIFO_LEVEL_EN to expose the FIFO occupancy on port 'level'.
module psg_write_fifo
  import psg_pkg::*;
#(
  parameter int unsigned DEPTH          = PSG_DEFAULT_DEPTH,
  parameter int unsigned HOLDOFF_CYCLES = PSG_DEFAULT_HOLDOFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] psg_data,
  output logic       psg_we_n,
  output logic       busy
`ifdef PSG_WRITE_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PSG_HOLD_W-1:0] HOLD_LOAD = PSG_HOLD_W'(HOLDOFF_CYCLES - 2);

  psg_state_e            state_q, state_d;
  logic [PSG_HOLD_W-1:0] cnt_q, cnt_d;
  logic [PSG_BYTE_W-1:0] data_q, data_d;
  logic                  we_n_q, we_n_d;

  logic                  pop_c;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PSG_BYTE_W-1:0] fifo_head;
  logic [CNT_W-1:0]      fifo_count;

  psg_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (in_valid),
    .push_data_i (in_data),
    .pop_i       (pop_c),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign in_ready = !fifo_full;
  assign psg_data = data_q;
  assign psg_we_n = we_n_q;
  assign busy     = (fifo_count != '0) || (state_q != IDLE);

`ifdef PSG_WRITE_FIFO_LEVEL_EN
  assign level = fifo_count;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      we_n_q  <= we_n_d;
    end
  end

  // Each pop loads the data bus and opens a one-cycle strobe; HOLD spaces consecutive strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    we_n_d  = 1'b1;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop_c   = 1'b1;
          data_d  = fifo_head;
          we_n_d  = 1'b0;
          state_d = STROBE;
        end
      end
      STROBE: begin
        cnt_d   = HOLD_LOAD;
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            pop_c   = 1'b1;
            data_d  = fifo_head;
            we_n_d  = 1'b0;
            state_d = STROBE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - PSG_HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_psg_write_fifo.sv
// Bench for psg_write_fifo: a strobe-schedule model (start = max(accept+1, previous start + HOLDOFF)) checked every cycle.
module tb_psg_write_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned H     = 32;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] psg_data;
  logic       psg_we_n;
  logic       busy;
`ifdef PSG_WRITE_FIFO_LEVEL_EN
  logic [CW-1:0] level;
`endif

  psg_write_fifo #(.DEPTH(DEPTH), .HOLDOFF_CYCLES(H)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .psg_data (psg_data),
    .psg_we_n (psg_we_n),
    .busy     (busy)
`ifdef PSG_WRITE_FIFO_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  int     n_cmp = 0;
  int     n_fail = 0;
  bit     mon_en = 0;
  longint cyc = 0;

  // Reference model state
  logic [7:0] q_data[$];
  longint     q_start[$];
  longint     m_last_sched;
  longint     m_last_start;
  logic [7:0] m_last_data;
  logic       exp_we_n;
  logic       exp_busy;
  int         occ;
  longint     st;

  // Observed strobes
  logic [7:0] log_data[$];
  longint     log_t[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle: compare DUT against the schedule model, then account for the upcoming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q_start.size() > 0 && q_start[0] == cyc) begin
        exp_we_n     = 1'b0;
        m_last_data  = q_data[0];
        m_last_start = cyc;
        void'(q_start.pop_front());
        void'(q_data.pop_front());
      end else begin
        exp_we_n = 1'b1;
      end
      n_cmp++;
      if (psg_we_n !== exp_we_n) begin
        n_fail++;
        $display("FAIL mon_we_n cyc=%0d got=%b exp=%b", cyc, psg_we_n, exp_we_n);
      end
      n_cmp++;
      if (psg_data !== m_last_data) begin
        n_fail++;
        $display("FAIL mon_data cyc=%0d got=%h exp=%h", cyc, psg_data, m_last_data);
      end
      occ = q_start.size();
      exp_busy = (occ > 0) || (cyc - m_last_start < longint'(H));
      n_cmp++;
      if (in_ready !== (occ < int'(DEPTH))) begin
        n_fail++;
        $display("FAIL mon_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (occ < int'(DEPTH)));
      end
      n_cmp++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
      end
`ifdef PSG_WRITE_FIFO_LEVEL_EN
      n_cmp++;
      if (level !== CW'(occ)) begin
        n_fail++;
        $display("FAIL mon_level cyc=%0d got=%0d exp=%0d", cyc, level, occ);
      end
`endif
      if (psg_we_n === 1'b0) begin
        log_t.push_back(cyc);
        log_data.push_back(psg_data);
      end
    end
    if (reset) begin
      q_data.delete();
      q_start.delete();
      m_last_sched = -1000;
      m_last_start = -1000;
      m_last_data  = 8'h00;
    end else if (mon_en && in_valid && q_start.size() < int'(DEPTH)) begin
      st = cyc + 2;
      if (m_last_sched + longint'(H) > st) st = m_last_sched + longint'(H);
      q_start.push_back(st);
      q_data.push_back(in_data);
      m_last_sched = st;
    end
  end

  // Holds in_valid until the byte is taken; returns the accepting edge index. Phase: #1 after posedge.
  task automatic push_byte(input logic [7:0] d, output longint k);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!acc && n < 5000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    k = acc ? cyc : -1;
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout data=%h got=not_accepted exp=accepted", d);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_t.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({psg_we_n, psg_data, busy, in_ready} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state got we_n=%b data=%h busy=%b rdy=%b exp 1 00 0 1",
               psg_we_n, psg_data, busy, in_ready);
    end
`ifdef PSG_WRITE_FIFO_LEVEL_EN
    n_cmp++;
    if (level !== CW'(0)) begin
      n_fail++;
      $display("FAIL reset_level got=%0d exp=0", level);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    bit ok;
    longint k;
    wait_idle(ok);
    push_byte(8'h8F, k);
    @(negedge clk);
    n_cmp++;
    if (psg_we_n !== 1'b1) begin
      n_fail++;
      $display("FAIL single_no_fallthrough got=%b exp=1", psg_we_n);
    end
    @(negedge clk);
    n_cmp++;
    if ({psg_we_n, psg_data} !== {1'b0, 8'h8F}) begin
      n_fail++;
      $display("FAIL single_strobe got=%b/%h exp=0/8f", psg_we_n, psg_data);
    end
    @(negedge clk);
    n_cmp++;
    if ({psg_we_n, psg_data} !== {1'b1, 8'h8F}) begin
      n_fail++;
      $display("FAIL single_after got=%b/%h exp=1/8f", psg_we_n, psg_data);
    end
    while (cyc < k + longint'(H)) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_hold got=%b exp=1", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_fall got=%b exp=0", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    longint k1, k2, k3;
    wait_idle(ok);
    clear_log();
    push_byte(8'h80, k1);
    push_byte(8'h3F, k2);
    push_byte(8'h9A, k3);
    wait_idle(ok);
    n_cmp++;
    if (!ok || log_t.size() != 3) begin
      n_fail++;
      $display("FAIL b2b_count got=%0d exp=3", log_t.size());
    end else begin
      n_cmp++;
      if ({log_data[0], log_data[1], log_data[2]} !== 24'h803F9A) begin
        n_fail++;
        $display("FAIL b2b_order got=%h%h%h exp=803f9a", log_data[0], log_data[1], log_data[2]);
      end
      n_cmp++;
      if (log_t[0] != k1 + 1 || log_t[1] != log_t[0] + H || log_t[2] != log_t[1] + H) begin
        n_fail++;
        $display("FAIL b2b_spacing got=%0d,%0d,%0d exp=%0d,+%0d,+%0d",
                 log_t[0], log_t[1], log_t[2], k1 + 1, H, H);
      end
    end
  endtask

  task automatic test_fill();
    bit ok;
    logic [7:0] d[10];
    longint k[10];
    wait_idle(ok);
    clear_log();
    for (int i = 0; i < 10; i++) d[i] = 8'($urandom);
    for (int i = 0; i < 10; i++) begin
      push_byte(d[i], k[i]);
      if (i == 8) begin
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL fill_full got=%b exp=0", in_ready);
        end
        @(posedge clk);
        #1;
      end
    end
    n_cmp++;
    if (k[9] != k[0] + H + 2) begin
      n_fail++;
      $display("FAIL fill_late_accept got=%0d exp=%0d", k[9], k[0] + H + 2);
    end
    wait_idle(ok);
    n_cmp++;
    if (log_t.size() != 10) begin
      n_fail++;
      $display("FAIL fill_count got=%0d exp=10", log_t.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        n_cmp++;
        if (log_data[i] !== d[i] || log_t[i] != k[0] + 1 + longint'(i) * H) begin
          n_fail++;
          $display("FAIL fill_entry%0d got=%h@%0d exp=%h@%0d", i, log_data[i], log_t[i],
                   d[i], k[0] + 1 + longint'(i) * H);
        end
      end
    end
  endtask

  task automatic test_simul();
    bit ok;
    longint k[4];
    logic [7:0] d[5];
    wait_idle(ok);
    clear_log();
    for (int i = 0; i < 5; i++) d[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) push_byte(d[i], k[i]);
    while (cyc < k[0] + longint'(H)) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d[4];
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_ready got=%b exp=1", in_ready);
    end
`ifdef PSG_WRITE_FIFO_LEVEL_EN
    n_cmp++;
    if (level !== CW'(3)) begin
      n_fail++;
      $display("FAIL simul_level_before got=%0d exp=3", level);
    end
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({psg_we_n, psg_data} !== {1'b0, d[1]}) begin
      n_fail++;
      $display("FAIL simul_pop got=%b/%h exp=0/%h", psg_we_n, psg_data, d[1]);
    end
`ifdef PSG_WRITE_FIFO_LEVEL_EN
    n_cmp++;
    if (level !== CW'(3)) begin
      n_fail++;
      $display("FAIL simul_level_after got=%0d exp=3", level);
    end
`endif
    @(posedge clk);
    #1;
    wait_idle(ok);
    n_cmp++;
    if (log_data.size() != 5) begin
      n_fail++;
      $display("FAIL simul_count got=%0d exp=5", log_data.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (log_data[i] !== d[i]) begin
          n_fail++;
          $display("FAIL simul_order%0d got=%h exp=%h", i, log_data[i], d[i]);
        end
      end
    end
  endtask

  task automatic test_reset_hold();
    bit ok;
    longint k0, kx;
    wait_idle(ok);
    push_byte(8'h11, k0);
    for (int i = 0; i < 4; i++) push_byte(8'(8'h20 + i), kx);
    while (cyc < k0 + 10) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({psg_we_n, busy, in_ready, psg_data} !== {1'b1, 1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL rst_hold_state got we_n=%b busy=%b rdy=%b data=%h exp 1 0 1 00",
               psg_we_n, busy, in_ready, psg_data);
    end
    @(posedge clk);
    #1;
    clear_log();
    repeat (3 * H) @(posedge clk);
    #1;
    n_cmp++;
    if (log_t.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_hold_quiet got strobes=%0d busy=%b exp 0 0", log_t.size(), busy);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    longint k;
    wait_idle(ok);
    clear_log();
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
      push_byte(8'(i), k);
    end
    wait_idle(ok);
    n_cmp++;
    if (log_data.size() != 20) begin
      n_fail++;
      $display("FAIL wrap_count got=%0d exp=20", log_data.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        n_cmp++;
        if (log_data[i] !== 8'(i)) begin
          n_fail++;
          $display("FAIL wrap_seq%0d got=%h exp=%h", i, log_data[i], 8'(i));
        end
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] exp_q[$];
    wait_idle(ok);
    clear_log();
    for (int i = 0; i < 500; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = 8'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) exp_q.push_back(in_data);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle(ok);
    n_cmp++;
    if (!ok || log_data.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count got=%0d exp=%0d", log_data.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (log_data[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL random_seq%0d got=%h exp=%h", i, log_data[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    m_last_sched = -1000;
    m_last_start = -1000;
    m_last_data  = 8'h00;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_simul();
    test_reset_hold();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
